// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and operand-issue stage: latches decoded fields, forwards
// EX/MEM and MEM/WB results into the ALU operands, and handles load-use, flush and stall.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [3:0]            id_alu_select,
  input  logic                  id_a_sel,
  input  logic                  id_b_sel,
  input  logic                  id_reg_we,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  mem_valid,
  input  logic                  mem_reg_we,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_result,
  input  logic                  wb_valid,
  input  logic                  wb_reg_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  input  logic                  ex_stall,
  output logic                  stall_id,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [3:0]            ex_alu_select,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_we,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [XLEN-1:0]       ex_store_data
);

  logic                  valid_q, valid_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]       imm_q, imm_d;
  logic [3:0]            alu_select_q, alu_select_d;
  logic                  a_sel_q, a_sel_d;
  logic                  b_sel_q, b_sel_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  reg_we_q, reg_we_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;

  logic                  hazard;
  logic [XLEN-1:0]       fwd_rs1;
  logic [XLEN-1:0]       fwd_rs2;

  // MEM beats WB; x0 is never forwarded. A load sitting in MEM cannot reach its
  // consumer here because the load-use bubble pushes the consumer one cycle later.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic [XLEN-1:0]       latched,
    input logic                  m_valid,
    input logic                  m_we,
    input logic [REG_ADDR_W-1:0] m_rd,
    input logic [XLEN-1:0]       m_res,
    input logic                  w_valid,
    input logic                  w_we,
    input logic [REG_ADDR_W-1:0] w_rd,
    input logic [XLEN-1:0]       w_dat
  );
    logic [XLEN-1:0] r;
    r = latched;
    if (m_valid && m_we && (m_rd != '0) && (m_rd == src)) begin
      r = m_res;
    end else if (w_valid && w_we && (w_rd != '0) && (w_rd == src)) begin
      r = w_dat;
    end
    return r;
  endfunction

  always_comb begin
    hazard = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
             ((id_rs1_used && (id_rs1 == rd_q)) || (id_rs2_used && (id_rs2 == rd_q)));
  end

  assign stall_id = ~reset & ((hazard & ~flush) | ex_stall);

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    alu_select_d = alu_select_q;
    a_sel_d      = a_sel_q;
    b_sel_d      = b_sel_q;
    rd_d         = rd_q;
    reg_we_d     = reg_we_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (ex_stall) begin
      valid_d = valid_q;
    end else if (hazard) begin
      // Bubble; ID stays frozen and the consumer re-issues next cycle.
      valid_d = 1'b0;
    end else begin
      valid_d      = id_valid;
      pc_d         = id_pc;
      rs1_d        = id_rs1;
      rs2_d        = id_rs2;
      rs1_data_d   = id_rs1_data;
      rs2_data_d   = id_rs2_data;
      imm_d        = id_imm;
      alu_select_d = id_alu_select;
      a_sel_d      = id_a_sel;
      b_sel_d      = id_b_sel;
      rd_d         = id_rd;
      reg_we_d     = id_reg_we;
      mem_read_d   = id_mem_read;
      mem_write_d  = id_mem_write;
    end
  end

  // ID -> EX boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      alu_select_q <= '0;
      a_sel_q      <= 1'b0;
      b_sel_q      <= 1'b0;
      rd_q         <= '0;
      reg_we_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      alu_select_q <= alu_select_d;
      a_sel_q      <= a_sel_d;
      b_sel_q      <= b_sel_d;
      rd_q         <= rd_d;
      reg_we_q     <= reg_we_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
    end
  end

  always_comb begin
    fwd_rs1 = fwd_sel(rs1_q, rs1_data_q, mem_valid, mem_reg_we, mem_rd, mem_result,
                      wb_valid, wb_reg_we, wb_rd, wb_data);
    fwd_rs2 = fwd_sel(rs2_q, rs2_data_q, mem_valid, mem_reg_we, mem_rd, mem_result,
                      wb_valid, wb_reg_we, wb_rd, wb_data);
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign alu_a         = a_sel_q ? pc_q : fwd_rs1;
  assign alu_b         = b_sel_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_alu_select = alu_select_q;
  assign ex_rd         = rd_q;
  assign ex_reg_we     = valid_q & reg_we_q;
  assign ex_mem_read   = valid_q & mem_read_q;
  assign ex_mem_write  = valid_q & mem_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding, load-use bubble, flush and stall.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [3:0]  id_alu_select;
  logic        id_a_sel, id_b_sel, id_reg_we, id_mem_read, id_mem_write;
  logic        mem_valid, mem_reg_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_valid, wb_reg_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush, ex_stall;
  logic        stall_id, ex_valid;
  logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;
  logic [3:0]  ex_alu_select;
  logic [4:0]  ex_rd;
  logic        ex_reg_we, ex_mem_read, ex_mem_write;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_select(id_alu_select), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_reg_we(id_reg_we), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_valid(mem_valid), .mem_reg_we(mem_reg_we), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_reg_we(wb_reg_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_stall(ex_stall), .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .alu_a(alu_a), .alu_b(alu_b), .ex_alu_select(ex_alu_select),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic u1, input logic u2,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic [3:0] sel, input logic as, input logic bs,
                        input logic we, input logic mr, input logic mw);
    id_valid = v; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rs1_used = u1; id_rs2_used = u2; id_rs1_data = d1; id_rs2_data = d2;
    id_imm = imm; id_alu_select = sel; id_a_sel = as; id_b_sel = bs;
    id_reg_we = we; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic clear_fwd();
    mem_valid = 0; mem_reg_we = 0; mem_rd = 0; mem_result = 0;
    wb_valid = 0; wb_reg_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  initial begin
    reset = 1; flush = 0; ex_stall = 0;
    clear_fwd();
    // add x5, x1, x2 presented during reset
    set_id(1, 32'h100, 5'd1, 5'd2, 5'd5, 1, 1, 32'h11, 32'h22, 32'h0, 4'h0, 0, 0, 1, 0, 0);
    step(); step();
    check("rst_valid", {31'b0, ex_valid}, 32'h0);
    check("rst_pc", ex_pc, 32'h0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_b", alu_b, 32'h0);
    check("rst_store", ex_store_data, 32'h0);
    check("rst_ctl", {27'b0, ex_reg_we, ex_mem_read, ex_mem_write, stall_id, ex_rd != 0}, 32'h0);
    reset = 0;
    #1;
    check("post_rst_valid", {31'b0, ex_valid}, 32'h0);
    check("post_rst_pc", ex_pc, 32'h0);

    step();
    check("add_valid", {31'b0, ex_valid}, 32'h1);
    check("add_pc", ex_pc, 32'h100);
    check("add_a", alu_a, 32'h11);
    check("add_b", alu_b, 32'h22);
    check("add_rd_we", {26'b0, ex_rd, ex_reg_we}, {26'b0, 5'd5, 1'b1});

    // consumer of x5 as rs1 with stale regfile data
    set_id(1, 32'h104, 5'd5, 5'd2, 5'd6, 1, 1, 32'hDEAD, 32'h22, 32'h0, 4'h1, 0, 0, 1, 0, 0);
    step();
    check("use_nofwd", alu_a, 32'hDEAD);
    mem_valid = 1; mem_reg_we = 1; mem_rd = 5; mem_result = 32'h10;
    #1 check("fwd_mem_a", alu_a, 32'h10);
    check("fwd_mem_sel", {28'b0, ex_alu_select}, 32'h1);
    clear_fwd();
    wb_valid = 1; wb_reg_we = 1; wb_rd = 5; wb_data = 32'h20;
    #1 check("fwd_wb_a", alu_a, 32'h20);

    // MEM beats WB on rs2
    clear_fwd();
    set_id(1, 32'h108, 5'd0, 5'd7, 5'd8, 0, 1, 32'h0, 32'h5555, 32'h44, 4'h2, 0, 0, 1, 0, 0);
    step();
    mem_valid = 1; mem_reg_we = 1; mem_rd = 7; mem_result = 32'hAAAA;
    wb_valid = 1; wb_reg_we = 1; wb_rd = 7; wb_data = 32'hBBBB;
    #1 check("prio_b", alu_b, 32'hAAAA);
    check("prio_store", ex_store_data, 32'hAAAA);
    mem_reg_we = 0;
    #1 check("wb_b", alu_b, 32'hBBBB);

    // x0 never forwarded
    set_id(1, 32'h10C, 5'd0, 5'd0, 5'd8, 1, 1, 32'h0, 32'h1234, 32'h44, 4'h2, 0, 0, 1, 0, 0);
    mem_reg_we = 1; mem_rd = 0; wb_rd = 0;
    step();
    check("x0_b", alu_b, 32'h1234);
    check("x0_a", alu_a, 32'h0);

    // b_sel=1: alu_b=imm, store data stays forwarded rs2
    clear_fwd();
    set_id(1, 32'h110, 5'd1, 5'd9, 5'd0, 1, 1, 32'h1, 32'h99, 32'h8, 4'h0, 1, 1, 0, 0, 1);
    step();
    mem_valid = 1; mem_reg_we = 1; mem_rd = 9; mem_result = 32'h5A5A;
    #1 check("imm_b", alu_b, 32'h8);
    check("pc_a", alu_a, 32'h110);
    check("store_fwd", ex_store_data, 32'h5A5A);
    check("store_mw", {31'b0, ex_mem_write}, 32'h1);

    // load-use: lw x3 then add x4, x3, x1
    clear_fwd();
    set_id(1, 32'h200, 5'd2, 5'd0, 5'd3, 1, 0, 32'h40, 32'h0, 32'h4, 4'h0, 0, 1, 1, 1, 0);
    step();
    check("lw_mr", {31'b0, ex_mem_read}, 32'h1);
    set_id(1, 32'h204, 5'd3, 5'd1, 5'd4, 1, 1, 32'hBAD, 32'h77, 32'h0, 4'h0, 0, 0, 1, 0, 0);
    #1 check("lu_stall", {31'b0, stall_id}, 32'h1);
    step();
    check("lu_bubble", {29'b0, ex_valid, ex_reg_we, ex_mem_read}, 32'h0);
    check("lu_stall_1cyc", {31'b0, stall_id}, 32'h0);
    mem_valid = 1; mem_reg_we = 1; mem_rd = 3; mem_result = 32'h9999;
    step();
    clear_fwd();
    wb_valid = 1; wb_reg_we = 1; wb_rd = 3; wb_data = 32'hCAFE;
    #1 check("lu_valid", {31'b0, ex_valid}, 32'h1);
    check("lu_a", alu_a, 32'hCAFE);
    check("lu_b", alu_b, 32'h77);
    check("lu_pc", ex_pc, 32'h204);

    // flush while EX holds a store
    clear_fwd();
    set_id(1, 32'h300, 5'd1, 5'd8, 5'd0, 1, 1, 32'h0, 32'h55, 32'h0, 4'h0, 0, 1, 0, 0, 1);
    step();
    check("st_mw", {31'b0, ex_mem_write}, 32'h1);
    set_id(1, 32'h304, 5'd1, 5'd2, 5'd3, 1, 1, 32'h1, 32'h2, 32'h0, 4'h0, 0, 0, 1, 0, 0);
    flush = 1;
    step();
    flush = 0;
    check("fl_valid_mw", {30'b0, ex_valid, ex_mem_write}, 32'h0);

    // flush together with a load-use hazard
    set_id(1, 32'h308, 5'd2, 5'd0, 5'd9, 1, 0, 32'h40, 32'h0, 32'h0, 4'h0, 0, 1, 1, 1, 0);
    step();
    set_id(1, 32'h30C, 5'd9, 5'd1, 5'd4, 1, 1, 32'h1, 32'h2, 32'h0, 4'h0, 0, 0, 1, 0, 0);
    flush = 1;
    #1 check("flhz_stall", {31'b0, stall_id}, 32'h0);
    step();
    flush = 0;
    check("flhz_valid", {31'b0, ex_valid}, 32'h0);
    #1 check("flhz_nohz", {31'b0, stall_id}, 32'h0);
    step();
    check("flhz_load", {31'b0, ex_valid}, 32'h1);
    check("flhz_pc", ex_pc, 32'h30C);

    // ex_stall holds EX for 3 cycles
    set_id(1, 32'h400, 5'd10, 5'd11, 5'd12, 1, 1, 32'h1010, 32'h2020, 32'h0, 4'h3, 0, 0, 1, 0, 0);
    step();
    set_id(1, 32'h500, 5'd13, 5'd14, 5'd15, 1, 1, 32'h3030, 32'h4040, 32'h0, 4'h5, 0, 0, 1, 0, 0);
    ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("stl_stall", {31'b0, stall_id}, 32'h1);
      step();
      check("stl_pc", ex_pc, 32'h400);
      check("stl_a", alu_a, 32'h1010);
      check("stl_sel_v", {27'b0, ex_alu_select, ex_valid}, {27'b0, 4'h3, 1'b1});
    end
    ex_stall = 0;
    #1 check("stl_rel", {31'b0, stall_id}, 32'h0);
    step();
    check("stl_pc_new", ex_pc, 32'h500);
    check("stl_a_new", alu_a, 32'h3030);
    check("stl_b_new", alu_b, 32'h4040);

    // ex_stall over a hazard: hold, then bubble after release
    set_id(1, 32'h600, 5'd2, 5'd0, 5'd6, 1, 0, 32'h40, 32'h0, 32'h0, 4'h0, 0, 1, 1, 1, 0);
    step();
    set_id(1, 32'h604, 5'd6, 5'd0, 5'd7, 1, 0, 32'h1, 32'h0, 32'h0, 4'h0, 0, 0, 1, 0, 0);
    ex_stall = 1;
    step();
    check("sthz_hold", {30'b0, ex_valid, ex_mem_read}, 32'h3);
    check("sthz_pc", ex_pc, 32'h600);
    ex_stall = 0;
    #1 check("sthz_stall", {31'b0, stall_id}, 32'h1);
    step();
    check("sthz_bubble", {31'b0, ex_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
